// File: rtl/alu_cmd_pkg.sv
// Shared opcode encodings, command payload and select decode for the ALU command issuer.
package alu_cmd_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned SEL_W = 4;

    localparam logic [OP_W-1:0] OP_MUL = 2'b00;
    localparam logic [OP_W-1:0] OP_ADD = 2'b01;
    localparam logic [OP_W-1:0] OP_DIV = 2'b10;
    localparam logic [OP_W-1:0] OP_SUB = 2'b11;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    // Bit 0 drives sel1 (mul) up to bit 3 driving sel4 (sub).
    function automatic logic [SEL_W-1:0] op_to_sel(input logic [OP_W-1:0] op);
        logic [SEL_W-1:0] sel;
        sel = '0;
        case (op)
            OP_MUL:  sel = 4'b0001;
            OP_ADD:  sel = 4'b0010;
            OP_DIV:  sel = 4'b0100;
            OP_SUB:  sel = 4'b1000;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_fifo.sv
// Registered-storage synchronous FIFO with flush; reads come from storage, so no fall-through.
module sync_fifo #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [W_DATA-1:0] wdata,
    input  logic              pop,
    output logic [W_DATA-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty_c,
    output logic              full_c
);

    logic [W_DATA-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CNT_W'(DEPTH));
    assign push_ok_c = push && !full_c && !flush;
    assign pop_ok_c  = pop && !empty_c && !flush;
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands and issues one per cycle as frozen-when-idle operands plus one-hot selects,
// with a result-valid pulse aligned to the ALU's registered output.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int unsigned W     = ALU_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   hold,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W-1:0]        cmd_op,
    input  logic [W-1:0]           cmd_a,
    input  logic [W-1:0]           cmd_b,
    output logic [W-1:0]           a_o,
    output logic [W-1:0]           b_o,
    output logic                   sel1,
    output logic                   sel2,
    output logic                   sel3,
    output logic                   sel4,
    output logic                   res_valid,
    output logic                   dz_err,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    cmd_t             push_cmd;
    cmd_t             head_cmd;
    logic             fifo_empty_c;
    logic             fifo_full_c;
    logic             push_c;
    logic             pop_c;
    logic             head_dz_c;
    logic [SEL_W-1:0] sel_q;
    logic             issue_q;
    logic             issue_dz_q;

    always_comb begin
        push_cmd    = '0;
        push_cmd.op = cmd_op;
        push_cmd.a  = ALU_W'(cmd_a);
        push_cmd.b  = ALU_W'(cmd_b);
    end

    assign cmd_ready = !fifo_full_c;
    assign push_c    = cmd_valid && cmd_ready && !flush;
    assign pop_c     = !fifo_empty_c && !hold && !flush;
    assign head_dz_c = (head_cmd.op == OP_DIV) && (head_cmd.b == '0);

    sync_fifo #(
        .W_DATA (CMD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push_c),
        .wdata   (push_cmd),
        .pop     (pop_c),
        .rdata   (head_cmd),
        .count   (fifo_cnt),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_c)
    );

    // Operands only move on a real issue, so the datapath sees no toggling while idle or on div-by-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_o        <= '0;
            b_o        <= '0;
            sel_q      <= '0;
            issue_q    <= 1'b0;
            issue_dz_q <= 1'b0;
            res_valid  <= 1'b0;
            dz_err     <= 1'b0;
        end else begin
            sel_q      <= '0;
            issue_q    <= pop_c;
            issue_dz_q <= pop_c && head_dz_c;
            res_valid  <= issue_q;
            dz_err     <= issue_dz_q;
            if (pop_c && !head_dz_c) begin
                a_o   <= W'(head_cmd.a);
                b_o   <= W'(head_cmd.b);
                sel_q <= op_to_sel(head_cmd.op);
            end
        end
    end

    assign {sel4, sel3, sel2, sel1} = sel_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural registered ALU downstream.
module tb_alu_cmd_issuer;
    import alu_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       hold;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] a_o;
    logic [3:0] b_o;
    logic       sel1, sel2, sel3, sel4;
    logic       res_valid;
    logic       dz_err;
    logic [2:0] fifo_cnt;
    logic [7:0] alu_out;

    int n_cmp = 0;
    int n_bad = 0;

    alu_cmd_issuer #(.W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (hold),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .a_o       (a_o),
        .b_o       (b_o),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .res_valid (res_valid),
        .dz_err    (dz_err),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    // Priority-select registered ALU; loads 0 when no select is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      alu_out <= '0;
        else if (sel1) alu_out <= 8'(a_o) * 8'(b_o);
        else if (sel2) alu_out <= 8'(a_o) + 8'(b_o);
        else if (sel3) alu_out <= 8'(a_o) / 8'(b_o);
        else if (sel4) alu_out <= 8'(a_o) - 8'(b_o);
        else           alu_out <= '0;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        step(); step();
        n_cmp++; if ({a_o, b_o} !== 8'h00) begin n_bad++; $display("FAIL reset_ops: got %h want 00", {a_o, b_o}); end
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0000) begin n_bad++; $display("FAIL reset_sel: got %b want 0000", {sel1, sel2, sel3, sel4}); end
        n_cmp++; if ({res_valid, dz_err} !== 2'b00) begin n_bad++; $display("FAIL reset_rv: got %b want 00", {res_valid, dz_err}); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
        rst = 1'b1;
        step();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt_after: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_single_add();
        drive(1'b1, OP_ADD, 4'd3, 4'd5);
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        n_cmp++; if (fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL add_cnt: got %0d want 1", fifo_cnt); end
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0000) begin n_bad++; $display("FAIL add_no_fallthrough: got %b want 0000", {sel1, sel2, sel3, sel4}); end
        step();
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0100) begin n_bad++; $display("FAIL add_sel: got %b want 0100", {sel1, sel2, sel3, sel4}); end
        n_cmp++; if ({a_o, b_o} !== {4'd3, 4'd5}) begin n_bad++; $display("FAIL add_ops: got %0d/%0d want 3/5", a_o, b_o); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL add_rv_early: got %b want 0", res_valid); end
        step();
        n_cmp++; if ({res_valid, dz_err} !== 2'b10) begin n_bad++; $display("FAIL add_rv: got %b want 10", {res_valid, dz_err}); end
        n_cmp++; if (alu_out !== 8'd8) begin n_bad++; $display("FAIL add_out: got %0d want 8", alu_out); end
        step();
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL add_rv_pulse: got %b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [4];
        int idx;
        int first;
        int last;
        exp_out = '{8'd225, 8'd5, 8'd4, 8'd2};
        hold = 1'b1;
        drive(1'b1, OP_MUL, 4'd15, 4'd15); step();
        drive(1'b1, OP_SUB, 4'd9, 4'd4);   step();
        drive(1'b1, OP_DIV, 4'd12, 4'd3);  step();
        drive(1'b1, OP_ADD, 4'd1, 4'd1);   step();
        drive(1'b1, OP_ADD, 4'd7, 4'd7);
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL b2b_full_cnt: got %0d want 4", fifo_cnt); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready: got %b want 0", cmd_ready); end
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0000) begin n_bad++; $display("FAIL b2b_hold_sel: got %b want 0000", {sel1, sel2, sel3, sel4}); end
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        n_cmp++; if (fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL b2b_refused: got %0d want 4", fifo_cnt); end
        hold = 1'b0;
        idx = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_valid === 1'b1) begin
                if (idx < 4) begin
                    n_cmp++; if (alu_out !== exp_out[idx]) begin n_bad++; $display("FAIL b2b_out%0d: got %0d want %0d", idx, alu_out, exp_out[idx]); end
                end
                if (first < 0) first = i;
                last = i;
                idx++;
            end
        end
        n_cmp++; if (idx !== 4) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 4", idx); end
        n_cmp++; if (last - first !== 3) begin n_bad++; $display("FAIL b2b_consecutive: got span %0d want 3", last - first); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL b2b_drained: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_div_zero();
        drive(1'b1, OP_ADD, 4'd2, 4'd2); step();
        drive(1'b1, OP_DIV, 4'd7, 4'd0); step();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0100) begin n_bad++; $display("FAIL dz_add_sel: got %b want 0100", {sel1, sel2, sel3, sel4}); end
        step();
        n_cmp++; if ({sel1, sel2, sel3, sel4} !== 4'b0000) begin n_bad++; $display("FAIL dz_sel: got %b want 0000", {sel1, sel2, sel3, sel4}); end
        n_cmp++; if ({a_o, b_o} !== {4'd2, 4'd2}) begin n_bad++; $display("FAIL dz_ops: got %0d/%0d want 2/2", a_o, b_o); end
        n_cmp++; if ({res_valid, dz_err} !== 2'b10) begin n_bad++; $display("FAIL dz_add_rv: got %b want 10", {res_valid, dz_err}); end
        n_cmp++; if (alu_out !== 8'd4) begin n_bad++; $display("FAIL dz_add_out: got %0d want 4", alu_out); end
        step();
        n_cmp++; if ({res_valid, dz_err} !== 2'b11) begin n_bad++; $display("FAIL dz_flag: got %b want 11", {res_valid, dz_err}); end
        n_cmp++; if (alu_out !== 8'd0) begin n_bad++; $display("FAIL dz_out: got %0d want 0", alu_out); end
        step();
        n_cmp++; if ({res_valid, dz_err} !== 2'b00) begin n_bad++; $display("FAIL dz_pulse: got %b want 00", {res_valid, dz_err}); end
    endtask

    task automatic test_idle();
        logic [3:0] a_prev;
        logic [3:0] b_prev;
        int toggles;
        int sel_seen;
        int rv_seen;
        a_prev = a_o; b_prev = b_o;
        toggles = 0; sel_seen = 0; rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_o !== a_prev || b_o !== b_prev) toggles++;
            a_prev = a_o; b_prev = b_o;
            if ({sel1, sel2, sel3, sel4} !== 4'b0000) sel_seen++;
            if (res_valid !== 1'b0) rv_seen++;
        end
        n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL idle_toggles: got %0d want 0", toggles); end
        n_cmp++; if (sel_seen !== 0) begin n_bad++; $display("FAIL idle_sel: got %0d want 0", sel_seen); end
        n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL idle_rv: got %0d want 0", rv_seen); end
        n_cmp++; if ({a_o, b_o} !== {4'd2, 4'd2}) begin n_bad++; $display("FAIL idle_ops: got %0d/%0d want 2/2", a_o, b_o); end
    endtask

    task automatic test_flush();
        int rv_seen;
        int sel_seen;
        hold = 1'b1;
        drive(1'b1, OP_ADD, 4'd1, 4'd2); step();
        drive(1'b1, OP_MUL, 4'd3, 4'd3); step();
        drive(1'b1, OP_SUB, 4'd8, 4'd1); step();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        n_cmp++; if (fifo_cnt !== 3'd3) begin n_bad++; $display("FAIL flush_queued: got %0d want 3", fifo_cnt); end
        hold = 1'b0;
        step();
        n_cmp++; if (fifo_cnt !== 3'd2) begin n_bad++; $display("FAIL flush_after_pop: got %0d want 2", fifo_cnt); end
        flush = 1'b1;
        drive(1'b1, OP_ADD, 4'd5, 4'd5);
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_cnt: got %0d want 0", fifo_cnt); end
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL flush_inflight_rv: got %b want 1", res_valid); end
        n_cmp++; if (alu_out !== 8'd3) begin n_bad++; $display("FAIL flush_inflight_out: got %0d want 3", alu_out); end
        rv_seen = 0; sel_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid !== 1'b0) rv_seen++;
            if ({sel1, sel2, sel3, sel4} !== 4'b0000) sel_seen++;
        end
        n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL flush_no_rv: got %0d want 0", rv_seen); end
        n_cmp++; if (sel_seen !== 0) begin n_bad++; $display("FAIL flush_no_sel: got %0d want 0", sel_seen); end
    endtask

    task automatic test_reset_mid();
        int rv_seen;
        int sel_seen;
        hold = 1'b1;
        drive(1'b1, OP_ADD, 4'd4, 4'd4); step();
        drive(1'b1, OP_MUL, 4'd2, 4'd3); step();
        drive(1'b1, OP_SUB, 4'd6, 4'd1); step();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        hold = 1'b0;
        step();
        n_cmp++; if (fifo_cnt !== 3'd2) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 2", fifo_cnt); end
        n_cmp++; if ({sel1, sel2, sel3, sel4, a_o} !== {4'b0100, 4'd4}) begin n_bad++; $display("FAIL rstmid_inflight: got %b want 01000100", {sel1, sel2, sel3, sel4, a_o}); end
        hold = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({a_o, b_o} !== 8'h00) begin n_bad++; $display("FAIL rstmid_ops: got %h want 00", {a_o, b_o}); end
        n_cmp++; if ({sel1, sel2, sel3, sel4, res_valid, dz_err} !== 6'b0) begin n_bad++; $display("FAIL rstmid_ctl: got %b want 000000", {sel1, sel2, sel3, sel4, res_valid, dz_err}); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL rstmid_fifo: got %0d want 0", fifo_cnt); end
        step();
        rst = 1'b1;
        hold = 1'b0;
        rv_seen = 0; sel_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid !== 1'b0) rv_seen++;
            if ({sel1, sel2, sel3, sel4} !== 4'b0000) sel_seen++;
        end
        n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_rv: got %0d want 0", rv_seen); end
        n_cmp++; if (sel_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_sel: got %0d want 0", sel_seen); end
        n_cmp++; if ({fifo_cnt, cmd_ready} !== {3'd0, 1'b1}) begin n_bad++; $display("FAIL rstmid_after: got cnt %0d ready %b want 0 1", fifo_cnt, cmd_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_div_zero();
        test_idle();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
